// File: rtl/digital_tube_driver_if.sv
// CPU-side write bus into the seven-segment tube peripheral.
// The master drives the strobe, register select and data; the tube driver listens.
interface digital_tube_driver_if;
  logic        iDoTubeWrite;
  logic [1:0]  iWriteAddress;
  logic [15:0] iWriteData;

  modport master (output iDoTubeWrite, output iWriteAddress, output iWriteData);
  modport slave  (input  iDoTubeWrite, input  iWriteAddress, input  iWriteData);
endinterface

// File: rtl/digital_tube_driver.sv
// Eight-digit multiplexed seven-segment driver with memory-mapped value/mask registers.
// Define DIGITAL_TUBE_ZERO_BLANK_EN to blank leading zero digits (digit 0 always shown).
module digital_tube_driver #(
  parameter int SCAN_DIVIDER  = 23000,
  parameter int COUNTER_WIDTH = 16
) (
  input  logic                      iCpuClock,
  input  logic                      iCpuReset,
  digital_tube_driver_if.slave      bus,
  output logic [7:0]                oDigitalTubeNotEnable,
  output logic [7:0]                oDigitalTubeShape
);

  localparam logic [COUNTER_WIDTH-1:0] PRESCALE_LAST = COUNTER_WIDTH'(SCAN_DIVIDER - 1);

  logic [31:0]              value;
  logic [7:0]               digit_mask;
  logic [7:0]               dp_mask;
  logic [COUNTER_WIDTH-1:0] prescaler;
  logic [2:0]               scan_index;

  logic [3:0] nibble;
  logic       digit_lit;
  logic [7:0] next_enable;
  logic [7:0] next_shape;

  // Only the low byte matters for the mask registers.
  logic unused_data_high;
  assign unused_data_high = ^bus.iWriteData[15:8];

  function automatic logic [6:0] glyph(input logic [3:0] hex);
    case (hex)
      4'h0: glyph = 7'h40;
      4'h1: glyph = 7'h79;
      4'h2: glyph = 7'h24;
      4'h3: glyph = 7'h30;
      4'h4: glyph = 7'h19;
      4'h5: glyph = 7'h12;
      4'h6: glyph = 7'h02;
      4'h7: glyph = 7'h78;
      4'h8: glyph = 7'h00;
      4'h9: glyph = 7'h10;
      4'hA: glyph = 7'h08;
      4'hB: glyph = 7'h03;
      4'hC: glyph = 7'h46;
      4'hD: glyph = 7'h21;
      4'hE: glyph = 7'h06;
      default: glyph = 7'h0E;
    endcase
  endfunction

  always_comb begin
    nibble    = value[{scan_index, 2'b00} +: 4];
    digit_lit = digit_mask[scan_index];
`ifdef DIGITAL_TUBE_ZERO_BLANK_EN
    if ((scan_index != 3'd0) && ((value >> {scan_index, 2'b00}) == 32'h0))
      digit_lit = 1'b0;
`endif
    next_enable = 8'hFF;
    next_shape  = 8'hFF;
    if (digit_lit) begin
      next_enable = ~(8'h01 << scan_index);
      next_shape  = {~dp_mask[scan_index], glyph(nibble)};
    end
  end

  // Outputs are re-registered every cycle so a register write shows one edge later.
  always_ff @(posedge iCpuClock) begin
    if (iCpuReset) begin
      value                 <= 32'h0;
      digit_mask            <= 8'hFF;
      dp_mask               <= 8'h00;
      prescaler             <= '0;
      scan_index            <= 3'd0;
      oDigitalTubeNotEnable <= 8'hFF;
      oDigitalTubeShape     <= 8'hFF;
    end else begin
      if (bus.iDoTubeWrite) begin
        case (bus.iWriteAddress)
          2'd0:    value[15:0]  <= bus.iWriteData;
          2'd1:    value[31:16] <= bus.iWriteData;
          2'd2:    digit_mask   <= bus.iWriteData[7:0];
          default: dp_mask      <= bus.iWriteData[7:0];
        endcase
      end
      if (prescaler == PRESCALE_LAST) begin
        prescaler  <= '0;
        scan_index <= scan_index + 3'd1;
      end else begin
        prescaler <= prescaler + 1'b1;
      end
      oDigitalTubeNotEnable <= next_enable;
      oDigitalTubeShape     <= next_shape;
    end
  end

endmodule

// File: tb/tb_digital_tube_driver.sv
// Scoreboard bench for digital_tube_driver: a behavioural model predicts the tube pins
// for every edge, pushes the prediction to a queue and the sampled pins are compared.
module tb_digital_tube_driver;
  localparam int SD = 4;

  logic       clk;
  logic       rst;
  logic [7:0] tube_enable;
  logic [7:0] tube_shape;

  digital_tube_driver_if bus ();

  digital_tube_driver #(.SCAN_DIVIDER(SD), .COUNTER_WIDTH(16)) dut (
    .iCpuClock             (clk),
    .iCpuReset             (rst),
    .bus                   (bus),
    .oDigitalTubeNotEnable (tube_enable),
    .oDigitalTubeShape     (tube_shape)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [7:0] glyph_table [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

  logic [31:0] m_value;
  logic [7:0]  m_mask;
  logic [7:0]  m_dp;
  int          m_presc;
  int          m_index;
  logic [15:0] exp_q [$];
  string       phase;
  int          check_count;
  int          error_count;

  function automatic logic [15:0] model_tube();
    logic       lit;
    logic [7:0] shape;
    lit = m_mask[m_index];
`ifdef DIGITAL_TUBE_ZERO_BLANK_EN
    if (m_index != 0 && (m_value >> (4 * m_index)) == 32'h0) lit = 1'b0;
`endif
    if (!lit) return 16'hFFFF;
    shape = glyph_table[m_value[4*m_index +: 4]];
    if (m_dp[m_index]) shape = shape & 8'h7F;
    return {~(8'h01 << m_index), shape};
  endfunction

  task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
    check_count++;
    if (observed !== expected) begin
      error_count++;
      $display("[TB] FAIL %s at %0t: got %h, expected %h", tag, $time, observed, expected);
    end
  endtask

  // One clock of stimulus: predict, advance the model, clock the DUT, compare.
  task automatic applyStimulus(input logic r, input logic wr, input logic [1:0] addr, input logic [15:0] data);
    logic [15:0] got;
    logic [15:0] want;
    rst = r;
    bus.iDoTubeWrite  = wr;
    bus.iWriteAddress = addr;
    bus.iWriteData    = data;
    exp_q.push_back(r ? 16'hFFFF : model_tube());
    if (r) begin
      m_value = 32'h0; m_mask = 8'hFF; m_dp = 8'h00; m_presc = 0; m_index = 0;
    end else begin
      if (wr) begin
        case (addr)
          2'd0: m_value[15:0]  = data;
          2'd1: m_value[31:16] = data;
          2'd2: m_mask         = data[7:0];
          2'd3: m_dp           = data[7:0];
        endcase
      end
      if (m_presc == SD - 1) begin
        m_presc = 0;
        m_index = (m_index + 1) % 8;
      end else begin
        m_presc++;
      end
    end
    @(posedge clk);
    #1;
    got  = {tube_enable, tube_shape};
    want = exp_q.pop_front();
    checkOutput(phase, got, want);
    checkOutput({phase, "_onehot"}, 16'($countones(~tube_enable) <= 1), 16'd1);
  endtask

  task automatic runIdle(input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b0, 1'b0, 2'd0, 16'h0);
  endtask

  initial begin
    check_count = 0;
    error_count = 0;
    m_value = 32'h0; m_mask = 8'hFF; m_dp = 8'h00; m_presc = 0; m_index = 0;

    phase = "reset";
    for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0, 2'd0, 16'h0);
    phase = "release";
    runIdle(2);
    checkOutput("release_digit0", {tube_enable, tube_shape}, 16'hFEC0);

    phase = "scan";
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h1234);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'hABCD);
    runIdle(36);

    phase = "masks";
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h0005);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'h0001);
    runIdle(34);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'hA5FF);
    applyStimulus(1'b0, 1'b1, 2'd3, 16'hFF00);

    phase = "wrap_write";
    for (int k = 0; k < 2 * SD && m_presc != SD - 1; k++) runIdle(1);
    applyStimulus(1'b0, 1'b1, 2'd0, 16'hFFFF);
    runIdle(10);

    phase = "reset_mid";
    for (int k = 0; k < 8 * SD && m_index != 5; k++) runIdle(1);
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h5555);
    runIdle(12);

    phase = "blank";
    applyStimulus(1'b0, 1'b1, 2'd0, 16'h00A0);
    applyStimulus(1'b0, 1'b1, 2'd1, 16'h0000);
    runIdle(36);

    $display("Simulation finished: %0d checks, %0d errors", check_count, error_count);
    $finish;
  end

endmodule
